// File: rtl/btn_pkg.sv
// Shared definitions for the button mode manager: key FSM encoding and mode width helper.
package btn_pkg;

  localparam logic [1:0] ST_LOCKED  = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_PRESSED = 2'd2;
  localparam logic [1:0] ST_REPEAT  = 2'd3;

  // Bank-select width, never narrower than one bit.
  function automatic int mode_w(input int n_modes);
    return (n_modes <= 2) ? 1 : $clog2(n_modes);
  endfunction

endpackage

// File: rtl/btn_key_channel.sv
// One key's press/hold/repeat FSM with repeat counter; pulse and level are registered.
// A mode-change event locks a held key until it is released.
module btn_key_channel
  import btn_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter bit REPEAT_EN     = 1'b0,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  input  logic mode_chg,
  output logic level,
  output logic pulse
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOCKED;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      // A bank switch must never let a held key act in the new bank.
      if (state != ST_LOCKED && mode_chg) begin
        state <= key ? ST_LOCKED : ST_IDLE;
      end else begin
        case (state)
          ST_LOCKED: begin
            if (!key) state <= ST_IDLE;
          end
          ST_IDLE: begin
            if (key) begin
              state <= ST_PRESSED;
              pulse <= 1'b1;
              cnt   <= '0;
            end
          end
          ST_PRESSED: begin
            if (!key) begin
              state <= ST_IDLE;
            end else if (REPEAT_EN && cnt == HOLD_LAST) begin
              state <= ST_REPEAT;
              pulse <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_REPEAT: begin
            if (!key) begin
              state <= ST_IDLE;
            end else if (cnt == REP_LAST) begin
              pulse <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: state <= ST_LOCKED;
        endcase
      end
    end
  end

  assign level = (state == ST_PRESSED) || (state == ST_REPEAT);

endmodule

// File: rtl/button_mode_manager.sv
// Routes debounced keys into the bank chosen by the registered mode, with press pulses,
// held levels, auto-repeat and lockout of keys held across a bank switch.
module button_mode_manager
  import btn_pkg::*;
#(
  parameter int                N_KEYS        = 4,
  parameter int                N_MODES       = 2,
  parameter int                HOLD_CYCLES   = 50_000_000,
  parameter int                REPEAT_CYCLES = 10_000_000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK   = '0,
  parameter int                CNT_W         = 26,
  // May be widened beyond the minimum when the switch field has spare bits.
  parameter int                MODE_W        = mode_w(N_MODES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [MODE_W-1:0]           mode,
  input  logic [N_KEYS-1:0]           key,
  output logic [N_MODES*N_KEYS-1:0]   level,
  output logic [N_MODES*N_KEYS-1:0]   pulse,
  output logic [MODE_W-1:0]           mode_q,
  output logic                        mode_err
);

  logic              mode_bad;
  logic              mode_chg;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_pulse;

  assign mode_bad = 32'(mode) >= 32'(N_MODES);
  assign mode_chg = mode_bad || (mode != mode_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= '0;
      mode_err <= 1'b0;
    end else begin
      mode_err <= mode_bad;
      if (!mode_bad && mode != mode_q) mode_q <= mode;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    btn_key_channel #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN    (REPEAT_MASK[k]),
      .CNT_W        (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .key     (key[k]),
      .mode_chg(mode_chg),
      .level   (key_level[k]),
      .pulse   (key_pulse[k])
    );
  end

  // Decoded purely from registers; mode_q only moves on edges that also lock held keys.
  always_comb begin
    level = '0;
    pulse = '0;
    for (int m = 0; m < N_MODES; m++) begin
      if (mode_q == MODE_W'(m)) begin
        level[m*N_KEYS +: N_KEYS] = key_level;
        pulse[m*N_KEYS +: N_KEYS] = key_pulse;
      end
    end
  end

endmodule

// File: tb/tb_button_mode_manager.sv
// Directed table-driven bench for button_mode_manager (2 banks x 4 keys, short hold/repeat).
module tb_button_mode_manager;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode_i;
  logic [3:0] key_i;
  logic [7:0] level;
  logic [7:0] pulse;
  logic [1:0] mode_q;
  logic       mode_err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] key;
    logic [7:0] level;
    logic [7:0] pulse;
    logic [1:0] mode_q;
    logic       err;
  } vec_t;

  vec_t vecs[27];

  always #5 clk = ~clk;

  button_mode_manager #(
    .N_KEYS       (4),
    .N_MODES      (2),
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .REPEAT_MASK  (4'b0001),
    .CNT_W        (26),
    .MODE_W       (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode_i),
    .key     (key_i),
    .level   (level),
    .pulse   (pulse),
    .mode_q  (mode_q),
    .mode_err(mode_err)
  );

  task automatic check(input string tag, input int idx, input logic [7:0] el,
                       input logic [7:0] ep, input logic [1:0] eq, input logic ee);
    n_vec++;
    if (level !== el) begin
      n_err++;
      $display("FAIL %s[%0d] level got %h want %h", tag, idx, level, el);
    end
    if (pulse !== ep) begin
      n_err++;
      $display("FAIL %s[%0d] pulse got %h want %h", tag, idx, pulse, ep);
    end
    if (mode_q !== eq) begin
      n_err++;
      $display("FAIL %s[%0d] mode_q got %0d want %0d", tag, idx, mode_q, eq);
    end
    if (mode_err !== ee) begin
      n_err++;
      $display("FAIL %s[%0d] mode_err got %b want %b", tag, idx, mode_err, ee);
    end
  endtask

  task automatic apply(input logic [1:0] m, input logic [3:0] k);
    @(negedge clk);
    mode_i = m;
    key_i  = k;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              mode  key      level  pulse  mode_q err
    vecs[0]  = '{2'd0, 4'b0000, 8'h00, 8'h00, 2'd0, 1'b0}; // locked -> idle
    vecs[1]  = '{2'd0, 4'b0010, 8'h02, 8'h02, 2'd0, 1'b0}; // single press
    vecs[2]  = '{2'd0, 4'b0010, 8'h02, 8'h00, 2'd0, 1'b0};
    vecs[3]  = '{2'd0, 4'b0000, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[4]  = '{2'd0, 4'b1111, 8'h0F, 8'h0F, 2'd0, 1'b0}; // simultaneous presses
    vecs[5]  = '{2'd0, 4'b1111, 8'h0F, 8'h00, 2'd0, 1'b0};
    vecs[6]  = '{2'd0, 4'b0000, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[7]  = '{2'd0, 4'b0001, 8'h01, 8'h01, 2'd0, 1'b0}; // release/re-press
    vecs[8]  = '{2'd0, 4'b0000, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[9]  = '{2'd0, 4'b0001, 8'h01, 8'h01, 2'd0, 1'b0};
    vecs[10] = '{2'd0, 4'b0000, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[11] = '{2'd0, 4'b0100, 8'h04, 8'h04, 2'd0, 1'b0}; // hold key2 in bank 0
    vecs[12] = '{2'd1, 4'b0100, 8'h00, 8'h00, 2'd1, 1'b0}; // switch -> locked
    vecs[13] = '{2'd1, 4'b0100, 8'h00, 8'h00, 2'd1, 1'b0};
    vecs[14] = '{2'd1, 4'b0000, 8'h00, 8'h00, 2'd1, 1'b0};
    vecs[15] = '{2'd1, 4'b0100, 8'h40, 8'h40, 2'd1, 1'b0}; // fresh press in bank 1
    vecs[16] = '{2'd1, 4'b0000, 8'h00, 8'h00, 2'd1, 1'b0};
    vecs[17] = '{2'd0, 4'b0000, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[18] = '{2'd0, 4'b0010, 8'h02, 8'h02, 2'd0, 1'b0};
    vecs[19] = '{2'd2, 4'b0010, 8'h00, 8'h00, 2'd0, 1'b1}; // illegal bank locks key
    vecs[20] = '{2'd2, 4'b0010, 8'h00, 8'h00, 2'd0, 1'b1};
    vecs[21] = '{2'd3, 4'b0000, 8'h00, 8'h00, 2'd0, 1'b1};
    vecs[22] = '{2'd2, 4'b0010, 8'h00, 8'h00, 2'd0, 1'b1}; // press during error ignored
    vecs[23] = '{2'd0, 4'b0010, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[24] = '{2'd0, 4'b0000, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[25] = '{2'd0, 4'b0010, 8'h02, 8'h02, 2'd0, 1'b0};
    vecs[26] = '{2'd0, 4'b0000, 8'h00, 8'h00, 2'd0, 1'b0};

    rst_n  = 1'b0;
    mode_i = 2'd0;
    key_i  = 4'b0000;
    #1;
    check("reset", 0, 8'h00, 8'h00, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      apply(vecs[i].mode, vecs[i].key);
      check("vec", i, vecs[i].level, vecs[i].pulse, vecs[i].mode_q, vecs[i].err);
    end

    // Auto-repeat on key 0 in bank 1: pulses after steps 1, 9, 13, 17.
    apply(2'd1, 4'b0000);
    check("rep_setup", 0, 8'h00, 8'h00, 2'd1, 1'b0);
    for (int j = 1; j <= 20; j++) begin
      apply(2'd1, 4'b0001);
      check("repeat", j, 8'h10,
            (j == 1 || j == 9 || j == 13 || j == 17) ? 8'h10 : 8'h00, 2'd1, 1'b0);
    end
    apply(2'd1, 4'b0000);
    check("rep_release", 0, 8'h00, 8'h00, 2'd1, 1'b0);

    // Reset asserted while key 1 is held in bank 1, then held through reset.
    apply(2'd1, 4'b0010);
    check("rst_seq", 0, 8'h20, 8'h20, 2'd1, 1'b0);
    apply(2'd1, 4'b0010);
    check("rst_seq", 1, 8'h20, 8'h00, 2'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 0, 8'h00, 8'h00, 2'd0, 1'b0);
    @(negedge clk);
    mode_i = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      apply(2'd0, 4'b0010);
      check("held_thru_rst", j, 8'h00, 8'h00, 2'd0, 1'b0);
    end
    apply(2'd0, 4'b0000);
    check("rst_release", 0, 8'h00, 8'h00, 2'd0, 1'b0);
    apply(2'd0, 4'b0010);
    check("rst_repress", 0, 8'h02, 8'h02, 2'd0, 1'b0);
    apply(2'd0, 4'b0010);
    check("rst_repress", 1, 8'h02, 8'h00, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
